// File: rtl/sc_reg_backg_bank_pkg.sv
// Shared encodings, default patterns and row-indexing helper for the
// multi-row background register bank.
package sc_backg_pkg;

    // Per-row direction and edge-fill encodings used by DIR_MASK / WRAP_MASK.
    localparam logic DIR_LEFT    = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;
    localparam logic MODE_FILL   = 1'b0;

    localparam logic [7:0] NEST_LEFT_DEFAULT  = 8'b1111_1011;
    localparam logic [7:0] NEST_RIGHT_DEFAULT = 8'b1101_1111;

    // Which source wins the next value of a row in a given cycle.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_CLEAR,
        SRC_NEST_LEFT,
        SRC_NEST_RIGHT,
        SRC_TRANSITION,
        SRC_LOAD,
        SRC_SHIFT
    } row_src_e;

    // Bit offset of row `row` inside a flattened bus of `width`-bit rows.
    function automatic int row_lsb(input int row, input int width);
        return row * width;
    endfunction

endpackage

// File: rtl/sc_reg_backg_bank_if.sv
// Control/data bundle between the game FSM (master) and the background
// register bank (slave).
interface sc_reg_backg_bank_if #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_ROWS  = 4,
    parameter int ROWADDR_W = 2,
    parameter int PERIOD_W  = 4
);
    logic                          SC_RegBACKGBANK_clear_InLow;
    logic                          SC_RegBACKGBANK_pause_InHigh;
    logic [PERIOD_W-1:0]           SC_RegBACKGBANK_period_In;
    logic                          SC_RegBACKGBANK_transition_InHigh;
    logic [NUM_ROWS*DATAWIDTH-1:0] SC_RegBACKGBANK_transitionDATA_InBUS;
    logic                          SC_RegBACKGBANK_load_InLow;
    logic [ROWADDR_W-1:0]          SC_RegBACKGBANK_loadaddr_In;
    logic [DATAWIDTH-1:0]          SC_RegBACKGBANK_data_InBUS;
    logic                          SC_RegBACKGBANK_NESTCHECK_left_InLow;
    logic                          SC_RegBACKGBANK_NESTCHECK_right_InLow;
    logic [NUM_ROWS*DATAWIDTH-1:0] SC_RegBACKGBANK_data_OutBUS;
    logic                          SC_RegBACKGBANK_tick_Out;

    modport master (
        output SC_RegBACKGBANK_clear_InLow,
        output SC_RegBACKGBANK_pause_InHigh,
        output SC_RegBACKGBANK_period_In,
        output SC_RegBACKGBANK_transition_InHigh,
        output SC_RegBACKGBANK_transitionDATA_InBUS,
        output SC_RegBACKGBANK_load_InLow,
        output SC_RegBACKGBANK_loadaddr_In,
        output SC_RegBACKGBANK_data_InBUS,
        output SC_RegBACKGBANK_NESTCHECK_left_InLow,
        output SC_RegBACKGBANK_NESTCHECK_right_InLow,
        input  SC_RegBACKGBANK_data_OutBUS,
        input  SC_RegBACKGBANK_tick_Out
    );

    modport slave (
        input  SC_RegBACKGBANK_clear_InLow,
        input  SC_RegBACKGBANK_pause_InHigh,
        input  SC_RegBACKGBANK_period_In,
        input  SC_RegBACKGBANK_transition_InHigh,
        input  SC_RegBACKGBANK_transitionDATA_InBUS,
        input  SC_RegBACKGBANK_load_InLow,
        input  SC_RegBACKGBANK_loadaddr_In,
        input  SC_RegBACKGBANK_data_InBUS,
        input  SC_RegBACKGBANK_NESTCHECK_left_InLow,
        input  SC_RegBACKGBANK_NESTCHECK_right_InLow,
        output SC_RegBACKGBANK_data_OutBUS,
        output SC_RegBACKGBANK_tick_Out
    );

endinterface

// File: rtl/sc_reg_backg_bank_tick_gen.sv
// Programmable-period tick generator: produces the combinational shift
// strobe for the rows and its registered copy for downstream consumers.
module sc_backg_tick_gen #(
    parameter int PERIOD_W = 4
) (
    input  logic                SC_RegBACKGBANK_CLOCK_50,
    input  logic                SC_RegBACKGBANK_RESET_InHigh,
    input  logic                SC_RegBACKGBANK_clear_InLow,
    input  logic                SC_RegBACKGBANK_pause_InHigh,
    input  logic [PERIOD_W-1:0] SC_RegBACKGBANK_period_In,
    output logic                SC_RegBACKGBANK_tickInt_Out,
    output logic                SC_RegBACKGBANK_tick_Out
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cntNext;
    logic                periodOn;
    logic                atLimit;

    assign periodOn = (SC_RegBACKGBANK_period_In != '0);

    // A ">=" compare rather than "==" makes a lowered period fire on the
    // next cycle instead of wrapping the counter through its full range.
    assign atLimit = (cnt >= (SC_RegBACKGBANK_period_In - PERIOD_W'(1)));

    assign SC_RegBACKGBANK_tickInt_Out = periodOn && atLimit &&
                                         !SC_RegBACKGBANK_pause_InHigh &&
                                         SC_RegBACKGBANK_clear_InLow;

    // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        cntNext = cnt;
        if (!SC_RegBACKGBANK_clear_InLow || !periodOn || SC_RegBACKGBANK_tickInt_Out) begin
            cntNext = '0;
        end else if (!SC_RegBACKGBANK_pause_InHigh) begin
            cntNext = cnt + PERIOD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge SC_RegBACKGBANK_CLOCK_50 or posedge SC_RegBACKGBANK_RESET_InHigh) begin
        if (SC_RegBACKGBANK_RESET_InHigh) begin
            cnt                      <= '0;
            SC_RegBACKGBANK_tick_Out <= 1'b0;
        end else begin
            cnt                      <= cntNext;
            SC_RegBACKGBANK_tick_Out <= SC_RegBACKGBANK_tickInt_Out;
        end
    end

endmodule

// File: rtl/sc_reg_backg_bank.sv
// Multi-row background register bank: each row rotates or shifts on a shared
// tick and can be cleared, bulk-loaded, row-loaded or nest-forced (row 0).
module sc_reg_backg_bank
    import sc_backg_pkg::*;
#(
    parameter int                            DATAWIDTH          = 8,
    parameter int                            NUM_ROWS           = 4,
    parameter int                            ROWADDR_W          = 2,
    parameter int                            PERIOD_W           = 4,
    parameter logic [NUM_ROWS*DATAWIDTH-1:0] INIT_PATTERN       = 32'h0F_3C_81_00,
    parameter logic [NUM_ROWS-1:0]           DIR_MASK           = 4'b0101,
    parameter logic [NUM_ROWS-1:0]           WRAP_MASK          = 4'b1111,
    parameter logic [DATAWIDTH-1:0]          NEST_LEFT_PATTERN  = NEST_LEFT_DEFAULT,
    parameter logic [DATAWIDTH-1:0]          NEST_RIGHT_PATTERN = NEST_RIGHT_DEFAULT
) (
    input  logic              SC_RegBACKGBANK_CLOCK_50,
    input  logic              SC_RegBACKGBANK_RESET_InHigh,
    sc_reg_backg_bank_if.slave bus
);

    logic                          tickInt;
    logic [NUM_ROWS*DATAWIDTH-1:0] rowsFlat;

    sc_backg_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .SC_RegBACKGBANK_CLOCK_50     (SC_RegBACKGBANK_CLOCK_50),
        .SC_RegBACKGBANK_RESET_InHigh (SC_RegBACKGBANK_RESET_InHigh),
        .SC_RegBACKGBANK_clear_InLow  (bus.SC_RegBACKGBANK_clear_InLow),
        .SC_RegBACKGBANK_pause_InHigh (bus.SC_RegBACKGBANK_pause_InHigh),
        .SC_RegBACKGBANK_period_In    (bus.SC_RegBACKGBANK_period_In),
        .SC_RegBACKGBANK_tickInt_Out  (tickInt),
        .SC_RegBACKGBANK_tick_Out     (bus.SC_RegBACKGBANK_tick_Out)
    );

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        localparam int   LSB     = row_lsb(r, DATAWIDTH);
        localparam logic ROW_DIR = DIR_MASK[r];
        localparam logic ROW_MOD = WRAP_MASK[r];

        logic [DATAWIDTH-1:0] rowQ;
        logic [DATAWIDTH-1:0] rowShift;
        logic [DATAWIDTH-1:0] rowNext;
        logic                 loadHit;
        logic                 edgeBit;
        row_src_e             rowSrc;

        // Out-of-range addresses simply never match any row index.
        assign loadHit = !bus.SC_RegBACKGBANK_load_InLow &&
                         (int'(bus.SC_RegBACKGBANK_loadaddr_In) == r);

        always_comb begin
            edgeBit  = 1'b0;
            rowShift = rowQ;
            if (ROW_DIR == DIR_LEFT) begin
                if (ROW_MOD == MODE_ROTATE) edgeBit = rowQ[DATAWIDTH-1];
                rowShift = {rowQ[DATAWIDTH-2:0], edgeBit};
            end else begin
                if (ROW_MOD == MODE_ROTATE) edgeBit = rowQ[0];
                rowShift = {edgeBit, rowQ[DATAWIDTH-1:1]};
            end
        end

        // Priority per row; the nest overrides exist only on row 0.
        always_comb begin
            rowSrc = SRC_HOLD;
            if (!bus.SC_RegBACKGBANK_clear_InLow) begin
                rowSrc = SRC_CLEAR;
            end else if ((r == 0) && !bus.SC_RegBACKGBANK_NESTCHECK_left_InLow) begin
                rowSrc = SRC_NEST_LEFT;
            end else if ((r == 0) && !bus.SC_RegBACKGBANK_NESTCHECK_right_InLow) begin
                rowSrc = SRC_NEST_RIGHT;
            end else if (bus.SC_RegBACKGBANK_transition_InHigh) begin
                rowSrc = SRC_TRANSITION;
            end else if (loadHit) begin
                rowSrc = SRC_LOAD;
            end else if (tickInt) begin
                rowSrc = SRC_SHIFT;
            end
        end

        always_comb begin
            rowNext = rowQ;
            case (rowSrc)
                SRC_CLEAR:      rowNext = INIT_PATTERN[LSB +: DATAWIDTH];
                SRC_NEST_LEFT:  rowNext = NEST_LEFT_PATTERN;
                SRC_NEST_RIGHT: rowNext = NEST_RIGHT_PATTERN;
                SRC_TRANSITION: rowNext = bus.SC_RegBACKGBANK_transitionDATA_InBUS[LSB +: DATAWIDTH];
                SRC_LOAD:       rowNext = bus.SC_RegBACKGBANK_data_InBUS;
                SRC_SHIFT:      rowNext = rowShift;
                default:        rowNext = rowQ;
            endcase
        end

        // NOTE: rows reset to zero, not INIT_PATTERN; the init pattern is applied only through clear.
        always_ff @(posedge SC_RegBACKGBANK_CLOCK_50 or posedge SC_RegBACKGBANK_RESET_InHigh) begin
            if (SC_RegBACKGBANK_RESET_InHigh) begin
                rowQ <= '0;
            end else begin
                rowQ <= rowNext;
            end
        end

        assign rowsFlat[LSB +: DATAWIDTH] = rowQ;
    end

    assign bus.SC_RegBACKGBANK_data_OutBUS = rowsFlat;

endmodule

// File: tb/tb_sc_reg_backg_bank.sv
// Scoreboard bench for sc_reg_backg_bank: stimulus queues expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_sc_reg_backg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance uses a 3-bit address so out-of-range rows can be addressed;
    // the second instance has every row in zero-fill mode.
    sc_reg_backg_bank_if #(.ROWADDR_W(3)) bus_a ();
    sc_reg_backg_bank_if #(.ROWADDR_W(2)) bus_f ();

    sc_reg_backg_bank #(
        .ROWADDR_W (3)
    ) u_dut (
        .SC_RegBACKGBANK_CLOCK_50     (clk),
        .SC_RegBACKGBANK_RESET_InHigh (rst),
        .bus                          (bus_a)
    );

    sc_reg_backg_bank #(
        .WRAP_MASK (4'b0000)
    ) u_fill (
        .SC_RegBACKGBANK_CLOCK_50     (clk),
        .SC_RegBACKGBANK_RESET_InHigh (rst),
        .bus                          (bus_f)
    );

    typedef struct {
        int          cyc;
        bit          inst;
        logic [31:0] data;
        logic        tick;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_out(input int after, input bit inst, input logic [31:0] d,
                              input logic t, input string nm);
        exp_t e;
        e.cyc  = cyc + after;
        e.inst = inst;
        e.data = d;
        e.tick = t;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        string       nm;
        logic [31:0] d_act;
        logic        t_act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: expectation for cycle %0d missed, now %0d", nm, e.cyc, cyc);
            end else begin
                d_act = e.inst ? bus_f.SC_RegBACKGBANK_data_OutBUS : bus_a.SC_RegBACKGBANK_data_OutBUS;
                t_act = e.inst ? bus_f.SC_RegBACKGBANK_tick_Out : bus_a.SC_RegBACKGBANK_tick_Out;
                check({nm, ".data"}, d_act, e.data);
                check({nm, ".tick"}, {31'd0, t_act}, {31'd0, e.tick});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] seed;

        bus_a.SC_RegBACKGBANK_clear_InLow           = 1'b1;
        bus_a.SC_RegBACKGBANK_pause_InHigh          = 1'b0;
        bus_a.SC_RegBACKGBANK_period_In             = '0;
        bus_a.SC_RegBACKGBANK_transition_InHigh     = 1'b0;
        bus_a.SC_RegBACKGBANK_transitionDATA_InBUS  = '0;
        bus_a.SC_RegBACKGBANK_load_InLow            = 1'b1;
        bus_a.SC_RegBACKGBANK_loadaddr_In           = '0;
        bus_a.SC_RegBACKGBANK_data_InBUS            = '0;
        bus_a.SC_RegBACKGBANK_NESTCHECK_left_InLow  = 1'b1;
        bus_a.SC_RegBACKGBANK_NESTCHECK_right_InLow = 1'b1;
        bus_f.SC_RegBACKGBANK_clear_InLow           = 1'b1;
        bus_f.SC_RegBACKGBANK_pause_InHigh          = 1'b0;
        bus_f.SC_RegBACKGBANK_period_In             = '0;
        bus_f.SC_RegBACKGBANK_transition_InHigh     = 1'b0;
        bus_f.SC_RegBACKGBANK_transitionDATA_InBUS  = '0;
        bus_f.SC_RegBACKGBANK_load_InLow            = 1'b1;
        bus_f.SC_RegBACKGBANK_loadaddr_In           = '0;
        bus_f.SC_RegBACKGBANK_data_InBUS            = '0;
        bus_f.SC_RegBACKGBANK_NESTCHECK_left_InLow  = 1'b1;
        bus_f.SC_RegBACKGBANK_NESTCHECK_right_InLow = 1'b1;

        step(2);
        expect_out(0, 1'b0, 32'h0000_0000, 1'b0, "reset_a");
        expect_out(0, 1'b1, 32'h0000_0000, 1'b0, "reset_f");
        rst = 1'b0;
        step(1);

        // Clear loads the init pattern into every row.
        bus_a.SC_RegBACKGBANK_clear_InLow = 1'b0;
        bus_f.SC_RegBACKGBANK_clear_InLow = 1'b0;
        expect_out(1, 1'b0, 32'h0F3C_8100, 1'b0, "clear_a");
        expect_out(1, 1'b1, 32'h0F3C_8100, 1'b0, "clear_f");
        step(1);

        // Period 3: tick on every third edge after clear.
        bus_a.SC_RegBACKGBANK_clear_InLow = 1'b1;
        bus_f.SC_RegBACKGBANK_clear_InLow = 1'b1;
        bus_a.SC_RegBACKGBANK_period_In   = 4'd3;
        expect_out(1, 1'b0, 32'h0F3C_8100, 1'b0, "p3_wait1");
        expect_out(2, 1'b0, 32'h0F3C_8100, 1'b0, "p3_wait2");
        expect_out(3, 1'b0, 32'h8778_C000, 1'b1, "p3_tick1");
        expect_out(4, 1'b0, 32'h8778_C000, 1'b0, "p3_hold");
        expect_out(6, 1'b0, 32'hC3F0_6000, 1'b1, "p3_tick2");
        step(8);

        // Row load in a tick cycle beats the shift for that row only.
        bus_a.SC_RegBACKGBANK_load_InLow  = 1'b0;
        bus_a.SC_RegBACKGBANK_loadaddr_In = 3'd2;
        bus_a.SC_RegBACKGBANK_data_InBUS  = 8'hAA;
        expect_out(1, 1'b0, 32'hE1AA_3000, 1'b1, "load_in_tick");
        step(1);
        bus_a.SC_RegBACKGBANK_loadaddr_In = 3'd4;
        bus_a.SC_RegBACKGBANK_data_InBUS  = 8'h55;
        expect_out(1, 1'b0, 32'hE1AA_3000, 1'b0, "addr4_ignored");
        step(1);
        bus_a.SC_RegBACKGBANK_loadaddr_In = 3'd7;
        expect_out(1, 1'b0, 32'hE1AA_3000, 1'b0, "addr7_ignored");
        step(1);
        bus_a.SC_RegBACKGBANK_loadaddr_In = 3'd5;
        expect_out(1, 1'b0, 32'hF055_1800, 1'b1, "addr5_tick_shifts_all");
        step(1);

        // Nest overrides with a simultaneous bulk transition.
        bus_a.SC_RegBACKGBANK_load_InLow            = 1'b1;
        bus_a.SC_RegBACKGBANK_period_In             = 4'd0;
        bus_a.SC_RegBACKGBANK_NESTCHECK_left_InLow  = 1'b0;
        bus_a.SC_RegBACKGBANK_NESTCHECK_right_InLow = 1'b0;
        bus_a.SC_RegBACKGBANK_transition_InHigh     = 1'b1;
        bus_a.SC_RegBACKGBANK_transitionDATA_InBUS  = 32'hFFFF_FFFF;
        expect_out(1, 1'b0, 32'hFFFF_FFFB, 1'b0, "nest_both_left_wins");
        step(1);
        bus_a.SC_RegBACKGBANK_NESTCHECK_left_InLow  = 1'b1;
        bus_a.SC_RegBACKGBANK_transition_InHigh     = 1'b0;
        expect_out(1, 1'b0, 32'hFFFF_FFDF, 1'b0, "nest_right");
        expect_out(3, 1'b0, 32'hFFFF_FFDF, 1'b0, "period0_hold");
        step(1);
        bus_a.SC_RegBACKGBANK_NESTCHECK_right_InLow = 1'b1;
        step(2);

        // Period 8, pause holds the count, then a lowered period fires at once.
        bus_a.SC_RegBACKGBANK_period_In = 4'd8;
        step(3);
        bus_a.SC_RegBACKGBANK_pause_InHigh = 1'b1;
        expect_out(1, 1'b0, 32'hFFFF_FFDF, 1'b0, "pause_hold1");
        expect_out(3, 1'b0, 32'hFFFF_FFDF, 1'b0, "pause_hold3");
        step(3);
        bus_a.SC_RegBACKGBANK_pause_InHigh = 1'b0;
        expect_out(1, 1'b0, 32'hFFFF_FFDF, 1'b0, "post_pause1");
        expect_out(2, 1'b0, 32'hFFFF_FFDF, 1'b0, "post_pause2");
        step(2);
        bus_a.SC_RegBACKGBANK_period_In = 4'd3;
        expect_out(1, 1'b0, 32'hFFFF_FFBF, 1'b1, "period_lowered_tick");
        expect_out(2, 1'b0, 32'hFFFF_FFBF, 1'b0, "after_lowered");
        step(3);
        bus_a.SC_RegBACKGBANK_pause_InHigh = 1'b1;
        expect_out(1, 1'b0, 32'hFFFF_FFBF, 1'b0, "pause_at_threshold");
        step(1);
        bus_a.SC_RegBACKGBANK_pause_InHigh = 1'b0;
        expect_out(1, 1'b0, 32'hFFFF_FF7F, 1'b1, "resume_tick");
        step(2);

        // Reset mid-count clears outputs before the next clock edge.
        expect_out(0, 1'b0, 32'h0000_0000, 1'b0, "async_reset");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_out(1, 1'b0, 32'h0000_0000, 1'b0, "release_wait1");
        expect_out(2, 1'b0, 32'h0000_0000, 1'b0, "release_wait2");
        expect_out(3, 1'b0, 32'h0000_0000, 1'b1, "release_first_tick");
        step(3);

        // Zero-fill instance: row 0 shifts left, row 1 shifts right, period 1.
        bus_f.SC_RegBACKGBANK_load_InLow  = 1'b0;
        bus_f.SC_RegBACKGBANK_loadaddr_In = 2'd0;
        bus_f.SC_RegBACKGBANK_data_InBUS  = 8'h81;
        step(1);
        bus_f.SC_RegBACKGBANK_loadaddr_In = 2'd1;
        expect_out(1, 1'b1, 32'h0000_8181, 1'b0, "fill_load");
        step(1);
        bus_f.SC_RegBACKGBANK_load_InLow = 1'b1;
        bus_f.SC_RegBACKGBANK_period_In  = 4'd1;
        seed = 8'h81;
        for (int k = 1; k <= 10; k++) begin
            r0 = seed << k;
            r1 = seed >> k;
            expect_out(k, 1'b1, {16'h0000, r1, r0}, 1'b1, $sformatf("fill_tick%0d", k));
        end
        step(12);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
